dcache_mem_ctrl: RTL and testbench

DCACHE_MEM_CTRL -- requirements
Module: dcache_mem_ctrl

---
 rtl/dcache_mem_ctrl_if.sv | 34 +++
 rtl/dcache_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_ctrl_if.sv
// Bus bundle between the data cache, the block memory controller and the byte-wide RAM.
// The controller uses the slave view; the cache/RAM side uses the master view.
interface dcache_mem_ctrl_if #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
);
    // Cache request side
    logic                      missIn;
    logic [31-BLOCK_WIDTH:0]   missAddrIn;
    logic                      readWriteIn;
    logic [BLOCK_SIZE*8-1:0]   writeBackIn;
    // Cache response side
    logic                      memDataValid;
    logic [31-BLOCK_WIDTH:0]   memAddr;
    logic [BLOCK_SIZE*8-1:0]   memDataOut;
    logic                      acceptWrite;
    // RAM side
    logic [7:0]                ramDataIn;
    logic [7:0]                ramDataOut;
    logic [31:0]               ramAddr;
    logic                      ramWrite;

    modport slave (
        input  missIn, missAddrIn, readWriteIn, writeBackIn, ramDataIn,
        output memDataValid, memAddr, memDataOut, acceptWrite,
               ramDataOut, ramAddr, ramWrite
    );

    modport master (
        output missIn, missAddrIn, readWriteIn, writeBackIn, ramDataIn,
        input  memDataValid, memAddr, memDataOut, acceptWrite,
               ramDataOut, ramAddr, ramWrite
    );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// Data-cache block memory controller: serialises a block fill or write-back into
// one RAM byte per cycle, then answers the cache with a one-cycle response pulse.
module dcache_mem_ctrl #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
    input  logic             clkIn,
    input  logic             resetIn,
    dcache_mem_ctrl_if.slave bus
);
    localparam int ADDR_W = 32 - BLOCK_WIDTH;
    localparam int DATA_W = BLOCK_SIZE * 8;
    localparam logic [BLOCK_WIDTH:0] LAST_RD = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
    localparam logic [BLOCK_WIDTH:0] LAST_WR = (BLOCK_WIDTH+1)'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateT;

    stateT                  state;
    stateT                  stateNext;
    logic [BLOCK_WIDTH:0]   cnt;
    logic [BLOCK_WIDTH-1:0] byteSel;
    logic [BLOCK_WIDTH-1:0] fillSel;
    logic                   accept;
    logic                   lastRead;

    logic [ADDR_W-1:0]      reqAddr;
    logic                   reqRead;
    logic [DATA_W-1:0]      reqData;
    logic [DATA_W-1:0]      fillBuf;
    logic [DATA_W-1:0]      fillData;

    logic                   memValidC;
    logic                   acceptC;
    logic [ADDR_W-1:0]      memAddrC;
    logic                   ramWriteC;
    logic [31:0]            ramAddrC;
    logic [7:0]             ramDataC;

    assign accept   = (state == IDLE) && bus.missIn;
    assign byteSel  = cnt[BLOCK_WIDTH-1:0];
    // Read data lags its address by one cycle, so it lands in the previous byte slot.
    assign fillSel  = byteSel - BLOCK_WIDTH'(1);
    assign lastRead = (state == READ) && (cnt == LAST_RD);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state    <= IDLE;
            cnt      <= '0;
            fillData <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                cnt <= '0;
            end else if (state == READ || state == WRITE) begin
                cnt <= cnt + (BLOCK_WIDTH+1)'(1);
            end
            if (lastRead) begin
                fillData <= {bus.ramDataIn, fillBuf[DATA_W-9:0]};
            end
        end
    end

    // NOTE: request latches and the fill buffer are pure datapath; nothing reads them
    // outside a transaction, so they carry no reset.
    always_ff @(posedge clkIn) begin
        if (accept) begin
            reqAddr <= bus.missAddrIn;
            reqRead <= bus.readWriteIn;
            reqData <= bus.writeBackIn;
        end
        if (state == READ && cnt != '0) begin
            fillBuf[{fillSel, 3'b000} +: 8] <= bus.ramDataIn;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        memValidC = 1'b0;
        acceptC   = 1'b0;
        memAddrC  = '0;
        ramWriteC = 1'b0;
        ramAddrC  = '0;
        ramDataC  = '0;
        case (state)
            IDLE: begin
                if (bus.missIn) begin
                    stateNext = bus.readWriteIn ? READ : WRITE;
                end
            end
            READ: begin
                if (cnt == LAST_RD) begin
                    stateNext = RESP;
                end else begin
                    ramAddrC = {reqAddr, byteSel};
                end
            end
            WRITE: begin
                ramWriteC = 1'b1;
                ramAddrC  = {reqAddr, byteSel};
                ramDataC  = reqData[{byteSel, 3'b000} +: 8];
                if (cnt == LAST_WR) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                stateNext = IDLE;
                memAddrC  = reqAddr;
                memValidC = reqRead;
                acceptC   = !reqRead;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.memDataValid = memValidC;
    assign bus.acceptWrite  = acceptC;
    assign bus.memAddr      = memAddrC;
    assign bus.memDataOut   = fillData;
    assign bus.ramWrite     = ramWriteC;
    assign bus.ramAddr      = ramAddrC;
    assign bus.ramDataOut   = ramDataC;
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Scoreboard bench for dcache_mem_ctrl: expected RAM traffic and responses are queued
// when a request is issued and checked by a monitor as the DUT produces them.
module tb_dcache_mem_ctrl;
    logic       clkIn;
    logic       resetIn;
    logic [7:0] ramSeed;

    dcache_mem_ctrl_if bus ();

    dcache_mem_ctrl dut (
        .clkIn   (clkIn),
        .resetIn (resetIn),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } ramOpT;

    typedef struct {
        logic [27:0]  addr;
        logic [127:0] data;
    } fillExpT;

    ramOpT       rdQ[$];
    ramOpT       wrQ[$];
    fillExpT     fillQ[$];
    logic [27:0] ackQ[$];

    int checks = 0;
    int errors = 0;

    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // RAM model: read byte appears one cycle after its address.
    always @(posedge clkIn) bus.ramDataIn <= ramSeed + {4'h0, bus.ramAddr[3:0]};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] fillPattern(input logic [7:0] seed);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = seed + 8'(i);
        return r;
    endfunction

    function automatic void pushFill(input logic [27:0] addr, input logic [7:0] seed);
        for (int i = 0; i < 16; i++) rdQ.push_back('{addr: {addr, 4'(i)}, data: 8'h00});
        fillQ.push_back('{addr: addr, data: fillPattern(seed)});
    endfunction

    function automatic void pushWb(input logic [27:0] addr, input logic [127:0] data);
        for (int i = 0; i < 16; i++) wrQ.push_back('{addr: {addr, 4'(i)}, data: data[8*i +: 8]});
        ackQ.push_back(addr);
    endfunction

    // Monitor: every RAM access and every response pulse must match the queue heads.
    ramOpT   monOp;
    fillExpT monFill;
    always @(negedge clkIn) begin
        if (!resetIn) begin
            if (bus.ramWrite) begin
                if (wrQ.size() == 0) check("unexpected ramWrite", 1, 0);
                else begin
                    monOp = wrQ.pop_front();
                    check("wr ramAddr", bus.ramAddr, monOp.addr);
                    check("wr ramDataOut", bus.ramDataOut, monOp.data);
                end
            end else begin
                if (bus.ramAddr != '0) begin
                    if (rdQ.size() == 0) check("unexpected read ramAddr", bus.ramAddr, 0);
                    else begin
                        monOp = rdQ.pop_front();
                        check("rd ramAddr", bus.ramAddr, monOp.addr);
                    end
                end
                if (bus.ramDataOut != '0) check("idle ramDataOut", bus.ramDataOut, 0);
            end
            if (bus.memDataValid) begin
                check("both pulses", bus.acceptWrite, 0);
                if (fillQ.size() == 0) check("unexpected memDataValid", 1, 0);
                else begin
                    monFill = fillQ.pop_front();
                    check("fill memAddr", bus.memAddr, monFill.addr);
                    check("fill memDataOut", bus.memDataOut, monFill.data);
                end
            end
            if (bus.acceptWrite) begin
                if (ackQ.size() == 0) check("unexpected acceptWrite", 1, 0);
                else check("wb memAddr", bus.memAddr, ackQ.pop_front());
            end
        end
    end

    // Counts edges until the requested pulse is seen at a falling edge.
    task automatic waitPulse(input string tag, input bit isFill, input int expEdges);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 64) begin
            @(posedge clkIn);
            n++;
            @(negedge clkIn);
            seen = isFill ? bus.memDataValid : bus.acceptWrite;
        end
        check(tag, n, expEdges);
    endtask

    // Issue one transaction from IDLE; scramble perturbs all inputs right after acceptance.
    task automatic doTxn(input string tag, input bit rw, input logic [27:0] addr,
                         input logic [127:0] wb, input logic [7:0] seed, input bit scramble);
        ramSeed = seed;
        if (rw) pushFill(addr, seed);
        else pushWb(addr, wb);
        bus.missIn      = 1'b1;
        bus.readWriteIn = rw;
        bus.missAddrIn  = addr;
        bus.writeBackIn = wb;
        @(posedge clkIn);
        @(negedge clkIn);
        bus.missIn = 1'b0;
        if (scramble) begin
            bus.readWriteIn = ~rw;
            bus.missAddrIn  = ~addr;
            bus.writeBackIn = ~wb;
        end
        waitPulse(tag, rw, rw ? 17 : 16);
        @(negedge clkIn);
    endtask

    task automatic checkOutputsZero(input string pfx);
        check({pfx, " memDataValid"}, bus.memDataValid, 0);
        check({pfx, " acceptWrite"}, bus.acceptWrite, 0);
        check({pfx, " ramWrite"}, bus.ramWrite, 0);
        check({pfx, " ramAddr"}, bus.ramAddr, 0);
        check({pfx, " ramDataOut"}, bus.ramDataOut, 0);
        check({pfx, " memAddr"}, bus.memAddr, 0);
        check({pfx, " memDataOut"}, bus.memDataOut, 0);
    endtask

    initial begin
        logic [127:0] wb;
        int n;
        resetIn         = 1'b1;
        ramSeed         = 8'h00;
        bus.missIn      = 1'b0;
        bus.readWriteIn = 1'b0;
        bus.missAddrIn  = '0;
        bus.writeBackIn = '0;
        #12;
        checkOutputsZero("reset");
        @(negedge clkIn);
        resetIn = 1'b0;
        @(negedge clkIn);

        doTxn("fill lat", 1'b1, 28'h0000123, '0, 8'h10, 1'b0);

        for (int i = 0; i < 16; i++) wb[8*i +: 8] = 8'(i);
        doTxn("wb lat", 1'b0, 28'h0000456, wb, 8'h00, 1'b0);
        check("memDataOut hold", bus.memDataOut, fillPattern(8'h10));

        for (int i = 0; i < 16; i++) wb[8*i +: 8] = 8'hC3 ^ 8'(i * 7);
        doTxn("stable wb lat", 1'b0, 28'h00002A5, wb, 8'h00, 1'b1);

        // Back-to-back: missIn stays high through RESP, second request is a fill.
        ramSeed = 8'h70;
        for (int i = 0; i < 16; i++) wb[8*i +: 8] = 8'h40 + 8'(i * 3);
        pushWb(28'h0000321, wb);
        pushFill(28'h0000654, 8'h70);
        bus.missIn      = 1'b1;
        bus.readWriteIn = 1'b0;
        bus.missAddrIn  = 28'h0000321;
        bus.writeBackIn = wb;
        @(posedge clkIn);
        @(negedge clkIn);
        bus.readWriteIn = 1'b1;
        bus.missAddrIn  = 28'h0000654;
        waitPulse("b2b wb lat", 1'b0, 16);
        @(posedge clkIn);
        @(negedge clkIn);
        check("b2b idle ramAddr", bus.ramAddr, 0);
        @(posedge clkIn);
        @(negedge clkIn);
        bus.missIn = 1'b0;
        waitPulse("b2b fill lat", 1'b1, 17);
        @(negedge clkIn);

        doTxn("wrap fill lat", 1'b1, 28'hFFFFFFF, '0, 8'hA0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            wb = {$urandom, $urandom, $urandom, $urandom};
            doTxn("rand lat", 1'($urandom_range(0, 1)), 28'($urandom_range(1, 32'h0FFFFFFE)),
                  wb, 8'($urandom), 1'b0);
        end

        // Async reset while byte 7 of a fill is on the RAM address bus.
        ramSeed = 8'h30;
        for (int i = 0; i < 8; i++) rdQ.push_back('{addr: {28'h0000789, 4'(i)}, data: 8'h00});
        bus.missIn      = 1'b1;
        bus.readWriteIn = 1'b1;
        bus.missAddrIn  = 28'h0000789;
        @(posedge clkIn);
        @(negedge clkIn);
        bus.missIn = 1'b0;
        n = 0;
        while (bus.ramAddr != 32'h00007897 && n < 32) begin
            @(negedge clkIn);
            n++;
        end
        check("rst reach byte7", bus.ramAddr, 32'h00007897);
        #1 resetIn = 1'b1;
        #1 checkOutputsZero("async rst");
        @(posedge clkIn);
        @(posedge clkIn);
        @(negedge clkIn);
        resetIn = 1'b0;
        doTxn("post rst fill lat", 1'b1, 28'h00000AB, '0, 8'h55, 1'b0);

        repeat (4) @(negedge clkIn);
        check("rdQ drained", rdQ.size(), 0);
        check("wrQ drained", wrQ.size(), 0);
        check("fillQ drained", fillQ.size(), 0);
        check("ackQ drained", ackQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
